// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared encodings and bundle widths for the pipelined core's control path.
//   - ResultSrc codes: which value a stage eventually writes back.
//   - Forward codes:   which source the EX operand muxes select.
//   - Control-bundle widths (register indices excluded) for the E, M and W
//     stage registers of control_pipeline.
// ----------------------------------------------------------------------------
package ctrl_pkg;

    // Write-back result source
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    // EX operand forwarding select
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Control bits per stage, excluding register indices.
    // E: RegWrite, MemWrite, ResultSrc[2], Branch, Jump, Jalr, ALUSrc, ALUOp[2]
    localparam int CTRL_E_W = 10;
    // M: RegWrite, MemWrite, ResultSrc[2]
    localparam int CTRL_M_W = 4;
    // W: RegWrite, ResultSrc[2]
    localparam int CTRL_W_W = 3;

endpackage

// File: rtl/ctrl_stage_reg.sv
// ----------------------------------------------------------------------------
// ctrl_stage_reg
// Generic pipeline stage register with synchronous clear and load enable.
// A clear (or reset) loads an all-zero bundle, i.e. a bubble.
// Ports:
//   clk   in  1  rising-edge clock
//   reset in  1  synchronous, active-high
//   en    in  1  load enable (hold when low)
//   clr   in  1  synchronous clear, wins over en
//   d     in  W  next-stage bundle
//   q     out W  registered bundle
// ----------------------------------------------------------------------------
module ctrl_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Next bundle: clear inserts a bubble, otherwise load or hold
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = {W{1'b0}};
        end else if (en) begin
            data_d = d;
        end else begin
            data_d = data_q;
        end
    end

    // Stage storage with synchronous reset to a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= {W{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/control_pipeline.sv
// ----------------------------------------------------------------------------
// control_pipeline
// Consumer end of the main decoder's control word. Carries decoded controls
// ID->EX->MEM->WB, detects load-use and control hazards, drives stall/flush
// to fetch/decode and selects EX operand forwarding.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   *D                         decoder controls and register indices (ID)
//   ZeroE                      ALU zero flag (EX)
//   *E / *M / *W               stage copies of the controls, Rd per stage
//   PCSrcE                     taken branch or jump in EX
//   StallF, StallD, FlushD, FlushE   hazard controls
//   ForwardAE, ForwardBE       00 regfile, 01 WB result, 10 MEM ALU result
//   stall_cnt, flush_cnt       hazard counters, present only when the macro
//                              HAZARD_CNT_EN is defined
// ----------------------------------------------------------------------------
module control_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWriteD,
    input  logic                  MemWriteD,
    input  logic                  BranchD,
    input  logic                  JumpD,
    input  logic                  JalrD,
    input  logic                  ALUSrcD,
    input  logic [1:0]            ResultSrcD,
    input  logic [1:0]            ALUOpD,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  ZeroE,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic [1:0]            ResultSrcE,
    output logic                  BranchE,
    output logic                  JumpE,
    output logic                  JalrE,
    output logic                  ALUSrcE,
    output logic [1:0]            ALUOpE,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic [1:0]            ResultSrcM,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic [REG_ADDR_W-1:0] RdM,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic                  PCSrcE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE
`ifdef HAZARD_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    localparam int E_W = CTRL_E_W + 3 * REG_ADDR_W;
    localparam int M_W = CTRL_M_W + REG_ADDR_W;
    localparam int W_W = CTRL_W_W + REG_ADDR_W;

    logic [E_W-1:0]        e_in_s;
    logic [E_W-1:0]        e_out_s;
    logic [M_W-1:0]        m_in_s;
    logic [M_W-1:0]        m_out_s;
    logic [W_W-1:0]        w_in_s;
    logic [W_W-1:0]        w_out_s;
    logic [REG_ADDR_W-1:0] rs1_e_s;
    logic [REG_ADDR_W-1:0] rs2_e_s;
    logic                  lw_stall_s;
    logic                  pc_src_s;

    // Operand source select; MEM is the younger producer so it wins over WB.
    // x0 is hard-wired, so a write to it is never a forwarding source.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  rw_m,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  rw_w,
        input logic [REG_ADDR_W-1:0] rd_w
    );
        logic [1:0] sel;
        if (rs == {REG_ADDR_W{1'b0}}) begin
            sel = FWD_RF;
        end else if (rw_m && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (rw_w && (rd_w == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Stage bundles: pack next-stage inputs
    always_comb begin
        e_in_s = {RegWriteD, MemWriteD, ResultSrcD, BranchD, JumpD, JalrD,
                  ALUSrcD, ALUOpD, Rs1D, Rs2D, RdD};
        m_in_s = {RegWriteE, MemWriteE, ResultSrcE, RdE};
        w_in_s = {RegWriteM, ResultSrcM, RdM};
    end

    // E never stalls: while decode is held, the flush feeds it a bubble instead.
    ctrl_stage_reg #(.W(E_W)) u_stage_e (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (FlushE),
        .d     (e_in_s),
        .q     (e_out_s)
    );

    ctrl_stage_reg #(.W(M_W)) u_stage_m (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .d     (m_in_s),
        .q     (m_out_s)
    );

    ctrl_stage_reg #(.W(W_W)) u_stage_w (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .d     (w_in_s),
        .q     (w_out_s)
    );

    assign {RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, JalrE,
            ALUSrcE, ALUOpE, rs1_e_s, rs2_e_s, RdE} = e_out_s;
    assign {RegWriteM, MemWriteM, ResultSrcM, RdM}   = m_out_s;
    assign {RegWriteW, ResultSrcW, RdW}              = w_out_s;

    // Hazard detection: load in EX whose destination a decode source needs
    always_comb begin
        lw_stall_s = 1'b0;
        if ((ResultSrcE == RES_MEM) && (RdE != {REG_ADDR_W{1'b0}}) &&
            ((Rs1D == RdE) || (Rs2D == RdE))) begin
            lw_stall_s = 1'b1;
        end else begin
            lw_stall_s = 1'b0;
        end
    end

    // Redirect and hazard controls; a redirect kills the dependent anyway, so no stall then
    always_comb begin
        pc_src_s  = (BranchE & ZeroE) | JumpE;
        PCSrcE    = pc_src_s;
        StallF    = lw_stall_s & ~pc_src_s;
        StallD    = lw_stall_s & ~pc_src_s;
        FlushD    = pc_src_s;
        FlushE    = lw_stall_s | pc_src_s;
    end

    // EX operand forwarding
    always_comb begin
        ForwardAE = fwd_sel(rs1_e_s, RegWriteM, RdM, RegWriteW, RdW);
        ForwardBE = fwd_sel(rs2_e_s, RegWriteM, RdM, RegWriteW, RdW);
    end

`ifdef HAZARD_CNT_EN
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;

    // Hazard counters: free-running, wrap naturally at 2^CNT_W
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallD) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (FlushE) begin
            flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter storage
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Counters disabled: CNT_W only sizes the optional ports
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_control_pipeline.sv
// ----------------------------------------------------------------------------
// tb_control_pipeline
// Directed bench for control_pipeline. A record-level model tracks which
// instruction occupies E, M and W and derives every output from the hazard
// and forwarding rules; a negedge process compares the DUT against it each
// cycle, and the stimulus adds hand-computed literal checks.
// Define HAZARD_CNT_EN to include the counter checks.
// ----------------------------------------------------------------------------
module tb_control_pipeline;

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic [1:0] rs;
        logic       br;
        logic       j;
        logic       jr;
        logic       as;
        logic [1:0] aop;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ins_t;

    logic clk;
    logic reset;
    logic zero_e;
    ins_t d_in;

    logic       RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE;
    logic [1:0] ResultSrcE, ALUOpE;
    logic       RegWriteM, MemWriteM, RegWriteW;
    logic [1:0] ResultSrcM, ResultSrcW;
    logic [4:0] RdE, RdM, RdW;
    logic       PCSrcE, StallF, StallD, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    control_pipeline #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteD  (d_in.rw),
        .MemWriteD  (d_in.mw),
        .BranchD    (d_in.br),
        .JumpD      (d_in.j),
        .JalrD      (d_in.jr),
        .ALUSrcD    (d_in.as),
        .ResultSrcD (d_in.rs),
        .ALUOpD     (d_in.aop),
        .Rs1D       (d_in.rs1),
        .Rs2D       (d_in.rs2),
        .RdD        (d_in.rd),
        .ZeroE      (zero_e),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .ResultSrcE (ResultSrcE),
        .BranchE    (BranchE),
        .JumpE      (JumpE),
        .JalrE      (JalrE),
        .ALUSrcE    (ALUSrcE),
        .ALUOpE     (ALUOpE),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .PCSrcE     (PCSrcE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE)
`ifdef HAZARD_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic check_en = 1'b0;

    // Model: the instruction record held in each stage, plus hazard counts
    ins_t        me, mm, mw;
    logic [31:0] m_stall_cnt, m_flush_cnt;

    initial begin
        me = '0;
        mm = '0;
        mw = '0;
        m_stall_cnt = 32'd0;
        m_flush_cnt = 32'd0;
    end

    function automatic ins_t mk(input logic rw, input logic mwr, input logic [1:0] rs,
                                input logic br, input logic j, input logic jr,
                                input logic as, input logic [1:0] aop,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd);
        ins_t x;
        x.rw = rw; x.mw = mwr; x.rs = rs; x.br = br; x.j = j; x.jr = jr;
        x.as = as; x.aop = aop; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
        return x;
    endfunction

    function automatic logic m_lw();
        return (me.rs == 2'b01) && (me.rd != 5'd0) &&
               ((d_in.rs1 == me.rd) || (d_in.rs2 == me.rd));
    endfunction

    function automatic logic m_pc();
        return (me.br && zero_e) || me.j;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (rs != 5'd0 && mm.rw && mm.rd == rs) return 2'b10;
        if (rs != 5'd0 && mw.rw && mw.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance: one instruction record moves per edge; flush or reset makes a bubble
    always @(posedge clk) begin
        if (reset) begin
            me <= '0;
            mm <= '0;
            mw <= '0;
            m_stall_cnt <= 32'd0;
            m_flush_cnt <= 32'd0;
        end else begin
            mw <= mm;
            mm <= me;
            me <= (m_lw() || m_pc()) ? ins_t'('0) : d_in;
            m_stall_cnt <= m_stall_cnt + ((m_lw() && !m_pc()) ? 32'd1 : 32'd0);
            m_flush_cnt <= m_flush_cnt + ((m_lw() || m_pc()) ? 32'd1 : 32'd0);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            check("RegWriteE",  {31'd0, RegWriteE},  {31'd0, me.rw});
            check("MemWriteE",  {31'd0, MemWriteE},  {31'd0, me.mw});
            check("ResultSrcE", {30'd0, ResultSrcE}, {30'd0, me.rs});
            check("BranchE",    {31'd0, BranchE},    {31'd0, me.br});
            check("JumpE",      {31'd0, JumpE},      {31'd0, me.j});
            check("JalrE",      {31'd0, JalrE},      {31'd0, me.jr});
            check("ALUSrcE",    {31'd0, ALUSrcE},    {31'd0, me.as});
            check("ALUOpE",     {30'd0, ALUOpE},     {30'd0, me.aop});
            check("RdE",        {27'd0, RdE},        {27'd0, me.rd});
            check("RegWriteM",  {31'd0, RegWriteM},  {31'd0, mm.rw});
            check("MemWriteM",  {31'd0, MemWriteM},  {31'd0, mm.mw});
            check("ResultSrcM", {30'd0, ResultSrcM}, {30'd0, mm.rs});
            check("RdM",        {27'd0, RdM},        {27'd0, mm.rd});
            check("RegWriteW",  {31'd0, RegWriteW},  {31'd0, mw.rw});
            check("ResultSrcW", {30'd0, ResultSrcW}, {30'd0, mw.rs});
            check("RdW",        {27'd0, RdW},        {27'd0, mw.rd});
            check("PCSrcE",     {31'd0, PCSrcE},     {31'd0, m_pc()});
            check("StallF",     {31'd0, StallF},     {31'd0, m_lw() && !m_pc()});
            check("StallD",     {31'd0, StallD},     {31'd0, m_lw() && !m_pc()});
            check("FlushD",     {31'd0, FlushD},     {31'd0, m_pc()});
            check("FlushE",     {31'd0, FlushE},     {31'd0, m_lw() || m_pc()});
            check("ForwardAE",  {30'd0, ForwardAE},  {30'd0, m_fwd(me.rs1)});
            check("ForwardBE",  {30'd0, ForwardBE},  {30'd0, m_fwd(me.rs2)});
`ifdef HAZARD_CNT_EN
            check("stall_cnt",  stall_cnt,           m_stall_cnt);
            check("flush_cnt",  flush_cnt,           m_flush_cnt);
`endif
        end
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        zero_e = 1'b0;
        d_in   = '0;
        edge_step();
        check_en = 1'b1;
        edge_step();
        reset = 1'b0;
        #2;
        check("rst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        check("rst_ForwardAE", {30'd0, ForwardAE}, 32'd0);
        check("rst_StallD",    {31'd0, StallD},    32'd0);

        // Load-use: lw x5 then a consumer of x5
        d_in = mk(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd1, 5'd0, 5'd5);
        edge_step();
        d_in = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd5, 5'd0, 5'd6);
        #2;
        check("lu_StallF", {31'd0, StallF}, 32'd1);
        check("lu_StallD", {31'd0, StallD}, 32'd1);
        check("lu_FlushE", {31'd0, FlushE}, 32'd1);
        check("lu_FlushD", {31'd0, FlushD}, 32'd0);
        edge_step();
        #2;
        check("lu_bubble_RegWriteE", {31'd0, RegWriteE}, 32'd0);
        check("lu_bubble_StallD",    {31'd0, StallD},    32'd0);
        edge_step();
        #2;
        check("lu_ForwardAE_wb", {30'd0, ForwardAE}, 32'd1);
        check("lu_RdE",          {27'd0, RdE},       32'd6);
        d_in = '0;

        // MEM beats WB when both hold x3
        d_in = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd3);
        edge_step();
        edge_step();
        d_in = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd3, 5'd3, 5'd7);
        edge_step();
        #2;
        check("fw_ForwardAE_mem", {30'd0, ForwardAE}, 32'd2);
        check("fw_ForwardBE_mem", {30'd0, ForwardBE}, 32'd2);

        // Taken branch flushes, untaken does not
        d_in = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 5'd1, 5'd2, 5'd0);
        edge_step();
        zero_e = 1'b1;
        d_in = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd9);
        #2;
        check("br_PCSrcE", {31'd0, PCSrcE}, 32'd1);
        check("br_FlushD", {31'd0, FlushD}, 32'd1);
        check("br_FlushE", {31'd0, FlushE}, 32'd1);
        check("br_StallF", {31'd0, StallF}, 32'd0);
        edge_step();
        #2;
        check("br_E_RegWrite", {31'd0, RegWriteE}, 32'd0);
        check("br_E_Branch",   {31'd0, BranchE},   32'd0);
        d_in = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 5'd1, 5'd2, 5'd0);
        edge_step();
        zero_e = 1'b0;
        d_in = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd9);
        #2;
        check("nbr_PCSrcE", {31'd0, PCSrcE}, 32'd0);
        check("nbr_FlushE", {31'd0, FlushE}, 32'd0);
        edge_step();
        #2;
        check("nbr_RdE", {27'd0, RdE}, 32'd9);

        // x0 never forwards and never stalls
        d_in = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd0, 5'd0, 5'd0);
        edge_step();
        d_in = '0;
        edge_step();
        #2;
        check("x0_ForwardAE", {30'd0, ForwardAE}, 32'd0);
        d_in = mk(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd1, 5'd0, 5'd0);
        edge_step();
        d_in = '0;
        #2;
        check("x0_StallD", {31'd0, StallD}, 32'd0);
        check("x0_FlushE", {31'd0, FlushE}, 32'd0);

        // Reset with valid controls in E/M/W
        d_in = mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 5'd4, 5'd4, 5'd4);
        edge_step();
        edge_step();
        edge_step();
        #2;
        check("pre_rst_RegWriteW", {31'd0, RegWriteW}, 32'd1);
        reset = 1'b1;
        edge_step();
        #2;
        check("mid_rst_RegWriteE", {31'd0, RegWriteE}, 32'd0);
        check("mid_rst_RegWriteM", {31'd0, RegWriteM}, 32'd0);
        check("mid_rst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        check("mid_rst_RdW",       {27'd0, RdW},       32'd0);
        check("mid_rst_ALUOpE",    {30'd0, ALUOpE},    32'd0);
        d_in = '0;
        edge_step();
        reset = 1'b0;

`ifdef HAZARD_CNT_EN
        // 3 load-use stalls and 2 taken jumps
        for (int i = 0; i < 3; i++) begin
            d_in = mk(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd1, 5'd0, 5'd5);
            edge_step();
            d_in = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd5, 5'd0, 5'd6);
            edge_step();
            d_in = '0;
            edge_step();
        end
        for (int i = 0; i < 2; i++) begin
            d_in = mk(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
            edge_step();
            d_in = '0;
            edge_step();
        end
        #2;
        check("cnt_stall", stall_cnt, 32'd3);
        check("cnt_flush", flush_cnt, 32'd5);
`endif

        edge_step();
        edge_step();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
